// File: rtl/servant_arb_pkg.sv
// Shared encodings for the servant RAM arbiter: grant codes, FSM states
// and the read data returned on an aborted (timed-out) access.
package servant_arb_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IBUS = 2'd1;
    localparam logic [1:0] GNT_DBUS = 2'd2;
    localparam logic [1:0] GNT_LBUS = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_RDT = 32'hDEADBEEF;

endpackage

// File: rtl/servant_arb_pick.sv
// Combinational winner selection: loader has absolute priority, the two
// CPU ports share the RAM round-robin (rr=0 favours ibus, rr=1 dbus).
module servant_arb_pick
    import servant_arb_pkg::*;
(
    input  logic       ibus_cyc,
    input  logic       dbus_cyc,
    input  logic       lbus_cyc,
    input  logic       rr,
    output logic [1:0] gnt
);

    // Priority encoder with round-robin tie break between the CPU ports
    always_comb begin
        gnt = GNT_NONE;
        if (lbus_cyc)
            gnt = GNT_LBUS;
        else if (ibus_cyc && dbus_cyc)
            gnt = rr ? GNT_DBUS : GNT_IBUS;
        else if (ibus_cyc)
            gnt = GNT_IBUS;
        else if (dbus_cyc)
            gnt = GNT_DBUS;
    end

endmodule

// File: rtl/servant_mem_arbiter.sv
// Three-way Wishbone arbiter in front of the servant RAM (ibus, dbus,
// loader). Grant is registered in IDLE and held for the whole access.
// Optional build macro SERVANT_ARB_TIMEOUT_EN adds a BUSY watchdog that
// aborts a stuck access with a fake ack and a sticky o_timeout flag.
module servant_mem_arbiter
    import servant_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter bit LOCK_LOADER = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    input  logic [AW-1:0] i_lbus_adr,
    input  logic [31:0]   i_lbus_dat,
    input  logic [3:0]    i_lbus_sel,
    input  logic          i_lbus_we,
    input  logic          i_lbus_cyc,
    output logic [31:0]   o_lbus_rdt,
    output logic          o_lbus_ack,
    output logic [AW-1:0] o_mem_adr,
    output logic [31:0]   o_mem_dat,
    output logic [3:0]    o_mem_sel,
    output logic          o_mem_we,
    output logic          o_mem_cyc,
    input  logic [31:0]   i_mem_rdt,
    input  logic          i_mem_ack,
    output logic [1:0]    o_gnt,
    output logic          o_timeout
);

    arb_state_t  state, state_nxt;
    logic [1:0]  gnt, gnt_nxt;
    logic        rr, rr_nxt;
    logic [1:0]  pick;
    logic        gnt_cyc;
    logic        real_ack;
    logic        abort;
    logic        resp;
    logic [31:0] rdt;

    servant_arb_pick u_pick (
        .ibus_cyc (i_ibus_cyc),
        .dbus_cyc (i_dbus_cyc),
        .lbus_cyc (i_lbus_cyc),
        .rr       (rr),
        .gnt      (pick)
    );

    // gnt is GNT_NONE in IDLE, so the granted cyc (and hence any ack) is
    // automatically suppressed outside BUSY.
    assign gnt_cyc  = ((gnt == GNT_IBUS) && i_ibus_cyc) ||
                      ((gnt == GNT_DBUS) && i_dbus_cyc) ||
                      ((gnt == GNT_LBUS) && i_lbus_cyc);
    assign real_ack = gnt_cyc && i_mem_ack;
    assign resp     = real_ack || abort;
    assign rdt      = abort ? TIMEOUT_RDT : i_mem_rdt;

`ifdef SERVANT_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // A real ack wins over a watchdog expiry landing in the same cycle
    assign abort     = gnt_cyc && !i_mem_ack && (cnt == CNT_W'(TIMEOUT));
    assign o_timeout = timeout_q;

    // Watchdog: counts unacked BUSY cycles, restarts on every ack and in IDLE
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_BUSY && !real_ack)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (abort)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign o_timeout      = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // State register: FSM state, current grant and round-robin pointer
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= ST_IDLE;
            gnt   <= GNT_NONE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            rr    <= rr_nxt;
        end
    end

    // Next state: grant in IDLE, release on ack/abort/dropped cyc in BUSY
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        case (state)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    state_nxt = ST_BUSY;
                    gnt_nxt   = pick;
                end
            end
            ST_BUSY: begin
                if (!gnt_cyc) begin
                    // Master gave up: release without touching rr
                    state_nxt = ST_IDLE;
                    gnt_nxt   = GNT_NONE;
                end else if (resp) begin
                    // A locked loader keeps the bus; its later cyc drop releases it
                    if (!((gnt == GNT_LBUS) && LOCK_LOADER && !abort)) begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = GNT_NONE;
                        if (gnt == GNT_IBUS)
                            rr_nxt = 1'b1;
                        else if (gnt == GNT_DBUS)
                            rr_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = GNT_NONE;
            end
        endcase
    end

    // Outputs: target request mux of the granted master, ack demux back
    always_comb begin
        o_mem_adr  = '0;
        o_mem_dat  = '0;
        o_mem_sel  = '0;
        o_mem_we   = 1'b0;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        o_lbus_ack = 1'b0;
        case (gnt)
            GNT_IBUS: begin
                o_mem_adr  = i_ibus_adr;
                o_mem_sel  = 4'hF;
                o_ibus_ack = resp;
            end
            GNT_DBUS: begin
                o_mem_adr  = i_dbus_adr;
                o_mem_dat  = i_dbus_dat;
                o_mem_sel  = i_dbus_sel;
                o_mem_we   = i_dbus_we;
                o_dbus_ack = resp;
            end
            GNT_LBUS: begin
                o_mem_adr  = i_lbus_adr;
                o_mem_dat  = i_lbus_dat;
                o_mem_sel  = i_lbus_sel;
                o_mem_we   = i_lbus_we;
                o_lbus_ack = resp;
            end
            default: ;
        endcase
        o_mem_cyc = gnt_cyc && !abort;
    end

    assign o_ibus_rdt = rdt;
    assign o_dbus_rdt = rdt;
    assign o_lbus_rdt = rdt;
    assign o_gnt      = gnt;

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Bench for servant_mem_arbiter: directed scenarios plus a randomized run,
// all checked cycle by cycle against an owner/turn model of the arbiter.
module tb_servant_mem_arbiter;

    localparam int AW   = 32;
    localparam bit LOCK = 1'b1;
`ifdef SERVANT_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic [AW-1:0] i_ibus_adr = '0;
    logic          i_ibus_cyc = 1'b0;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;
    logic [AW-1:0] i_dbus_adr = '0;
    logic [31:0]   i_dbus_dat = '0;
    logic [3:0]    i_dbus_sel = '0;
    logic          i_dbus_we  = 1'b0;
    logic          i_dbus_cyc = 1'b0;
    logic [31:0]   o_dbus_rdt;
    logic          o_dbus_ack;
    logic [AW-1:0] i_lbus_adr = '0;
    logic [31:0]   i_lbus_dat = '0;
    logic [3:0]    i_lbus_sel = '0;
    logic          i_lbus_we  = 1'b0;
    logic          i_lbus_cyc = 1'b0;
    logic [31:0]   o_lbus_rdt;
    logic          o_lbus_ack;
    logic [AW-1:0] o_mem_adr;
    logic [31:0]   o_mem_dat;
    logic [3:0]    o_mem_sel;
    logic          o_mem_we;
    logic          o_mem_cyc;
    logic [31:0]   i_mem_rdt = '0;
    logic          i_mem_ack = 1'b0;
    logic [1:0]    o_gnt;
    logic          o_timeout;

    always #5 wb_clk = ~wb_clk;

    servant_mem_arbiter #(
        .AW          (AW),
        .LOCK_LOADER (LOCK),
        .TIMEOUT     (TMO)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .i_lbus_adr (i_lbus_adr),
        .i_lbus_dat (i_lbus_dat),
        .i_lbus_sel (i_lbus_sel),
        .i_lbus_we  (i_lbus_we),
        .i_lbus_cyc (i_lbus_cyc),
        .o_lbus_rdt (o_lbus_rdt),
        .o_lbus_ack (o_lbus_ack),
        .o_mem_adr  (o_mem_adr),
        .o_mem_dat  (o_mem_dat),
        .o_mem_sel  (o_mem_sel),
        .o_mem_we   (o_mem_we),
        .o_mem_cyc  (o_mem_cyc),
        .i_mem_rdt  (i_mem_rdt),
        .i_mem_ack  (i_mem_ack),
        .o_gnt      (o_gnt),
        .o_timeout  (o_timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM (0 none, 1 ibus, 2 dbus, 3 lbus),
    // whose turn it is among the CPU ports, watchdog count, sticky abort.
    int          m_own = 0;
    int          m_rr  = 1;
    int          m_cnt = 0;
    bit          m_to  = 1'b0;
    bit          gc, ack, fire;
    logic [2:0]  e_ack;
    logic [31:0] e_rdt, e_dat;
    logic [AW-1:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_we;

    // Observation side: grants seen at each ack, per-master ack counts
    int          glog[$];
    int          ack_cnt[4];
    logic [31:0] cap_rdt = '0;
    bit          last_mem_cyc = 1'b0;
    int          tgt_mode = 1;

    always @(negedge wb_clk) begin
        if (wb_rst) begin
            m_own = 0;
            m_rr  = 1;
            m_cnt = 0;
            m_to  = 1'b0;
        end
        case (m_own)
            1: gc = i_ibus_cyc;
            2: gc = i_dbus_cyc;
            3: gc = i_lbus_cyc;
            default: gc = 1'b0;
        endcase
        ack  = gc && i_mem_ack;
        fire = 1'b0;
`ifdef SERVANT_ARB_TIMEOUT_EN
        fire = gc && !i_mem_ack && (m_cnt == TMO);
`endif
        e_ack = 3'b000;
        if (ack || fire)
            e_ack[m_own-1] = 1'b1;
        e_rdt = fire ? 32'hDEADBEEF : i_mem_rdt;

        check("gnt", o_gnt, m_own);
        check("mem_cyc", o_mem_cyc, gc && !fire);
        check("acks", {o_lbus_ack, o_dbus_ack, o_ibus_ack}, e_ack);
        check("timeout", o_timeout, m_to);
        if (m_own != 0) begin
            case (m_own)
                1: begin e_adr = i_ibus_adr; e_dat = '0; e_sel = 4'hF; e_we = 1'b0; end
                2: begin e_adr = i_dbus_adr; e_dat = i_dbus_dat; e_sel = i_dbus_sel; e_we = i_dbus_we; end
                default: begin e_adr = i_lbus_adr; e_dat = i_lbus_dat; e_sel = i_lbus_sel; e_we = i_lbus_we; end
            endcase
            check("mem_adr", o_mem_adr, e_adr);
            check("mem_dat", o_mem_dat, e_dat);
            check("mem_sel", o_mem_sel, e_sel);
            check("mem_we", o_mem_we, e_we);
        end
        if (ack || fire) begin
            case (m_own)
                1: check("ibus_rdt", o_ibus_rdt, e_rdt);
                2: check("dbus_rdt", o_dbus_rdt, e_rdt);
                default: check("lbus_rdt", o_lbus_rdt, e_rdt);
            endcase
        end else begin
            check("rdt_bcast", o_dbus_rdt, i_mem_rdt);
        end

        if (o_ibus_ack || o_dbus_ack || o_lbus_ack) begin
            glog.push_back(int'(o_gnt));
            ack_cnt[o_gnt]++;
            cap_rdt = o_ibus_ack ? o_ibus_rdt : (o_dbus_ack ? o_dbus_rdt : o_lbus_rdt);
        end
        last_mem_cyc = o_mem_cyc;

        if (!wb_rst) begin
            if (fire)
                m_to = 1'b1;
            if (m_own == 0) begin
                m_cnt = 0;
                if (i_lbus_cyc)
                    m_own = 3;
                else if (i_ibus_cyc && i_dbus_cyc)
                    m_own = m_rr;
                else if (i_ibus_cyc)
                    m_own = 1;
                else if (i_dbus_cyc)
                    m_own = 2;
            end else if (!gc) begin
                m_own = 0;
            end else if (ack || fire) begin
                m_cnt = 0;
                if (!(m_own == 3 && LOCK && !fire)) begin
                    if (m_own != 3)
                        m_rr = 3 - m_own;
                    m_own = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    end

    // Advance one clock; the target answers per tgt_mode
    // (0 random, 1 registered ack after cyc, 2 never, 3 always)
    task automatic tick();
        @(posedge wb_clk);
        #1;
        case (tgt_mode)
            0: i_mem_ack = 1'($urandom_range(0, 1));
            1: i_mem_ack = last_mem_cyc && !i_mem_ack;
            3: i_mem_ack = 1'b1;
            default: i_mem_ack = 1'b0;
        endcase
    endtask

    task automatic reset_pulse();
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        tick();
    endtask

    // Each master keeps cyc high until it has collected its wanted acks
    task automatic run_phase(input int wl, input int wi, input int wd, input int ncyc);
        for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
        glog.delete();
        repeat (ncyc) begin
            i_lbus_cyc = (ack_cnt[3] < wl);
            i_ibus_cyc = (ack_cnt[1] < wi);
            i_dbus_cyc = (ack_cnt[2] < wd);
            tick();
        end
        i_lbus_cyc = 1'b0;
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
    endtask

    // seq packs the expected grants, first one in bits [1:0]
    task automatic check_log(input string tag, input int n, input logic [7:0] seq);
        logic [7:0] s;
        s = seq;
        check({tag, "_count"}, glog.size(), n);
        for (int k = 0; k < n; k++)
            check(tag, (k < glog.size()) ? glog[k] : 99, s[2*k +: 2]);
    endtask

    initial begin
        tick();
        tick();
        check("rst_gnt", o_gnt, 2'd0);
        check("rst_mem_cyc", o_mem_cyc, 1'b0);
        check("rst_acks", {o_lbus_ack, o_dbus_ack, o_ibus_ack}, 3'b000);
        check("rst_timeout", o_timeout, 1'b0);
        wb_rst = 1'b0;
        tick();

        // Lone ibus fetch
        tgt_mode   = 1;
        i_ibus_adr = 32'h100;
        i_mem_rdt  = 32'h13;
        run_phase(0, 1, 0, 10);
        check_log("p1_log", 1, 8'h01);
        check("p1_rdt", cap_rdt, 32'h13);

        // ibus and dbus contend continuously: strict alternation from ibus
        reset_pulse();
        i_dbus_adr = 32'h200;
        i_dbus_sel = 4'h3;
        run_phase(0, 2, 2, 24);
        check_log("p2_log", 4, 8'h99);

        // Loader write beats a pending dbus access
        i_lbus_adr = 32'h40;
        i_lbus_dat = 32'hCAFEF00D;
        i_lbus_sel = 4'hF;
        i_lbus_we  = 1'b1;
        run_phase(1, 0, 1, 16);
        check_log("p3_log", 2, 8'h0B);

        // Locked loader: three back-to-back writes before ibus gets in
        run_phase(3, 1, 0, 24);
        check_log("p4_log", 4, 8'h7F);

        // dbus abandons its access; late target acks are ignored
        glog.delete();
        tgt_mode   = 2;
        i_dbus_cyc = 1'b1;
        tick();
        tick();
        tick();
        check("p5_busy_gnt", o_gnt, 2'd2);
        i_dbus_cyc = 1'b0;
        tick();
        tgt_mode = 3;
        tick();
        tick();
        check("p5_no_ack", glog.size(), 0);
        tgt_mode = 2;
        tick();
        // rr still favours dbus after the abandoned access
        tgt_mode = 1;
        run_phase(0, 1, 1, 16);
        check_log("p5_log", 2, 8'h06);

        // Reset in the middle of a BUSY ibus access
        tgt_mode   = 2;
        i_ibus_cyc = 1'b1;
        tick();
        tick();
        check("pre_rst_gnt", o_gnt, 2'd1);
        wb_rst = 1'b1;
        #1;
        check("midrst_gnt", o_gnt, 2'd0);
        check("midrst_mem_cyc", o_mem_cyc, 1'b0);
        check("midrst_ack", o_ibus_ack, 1'b0);
        tick();
        i_ibus_cyc = 1'b0;
        wb_rst     = 1'b0;
        tick();

`ifdef SERVANT_ARB_TIMEOUT_EN
        // Target never answers a dbus read: watchdog fakes the ack
        tgt_mode  = 2;
        i_dbus_we = 1'b0;
        run_phase(0, 0, 1, 25);
        check_log("to_log", 1, 8'h02);
        check("to_rdt", cap_rdt, 32'hDEADBEEF);
        check("to_sticky", o_timeout, 1'b1);
        wb_rst = 1'b1;
        #1;
        check("to_cleared", o_timeout, 1'b0);
        tick();
        wb_rst = 1'b0;
        tick();
`endif

        // Randomized traffic, random target timing, occasional reset
        tgt_mode = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) i_ibus_cyc = ~i_ibus_cyc;
            if ($urandom_range(0, 3) == 0) i_dbus_cyc = ~i_dbus_cyc;
            if ($urandom_range(0, 7) == 0) i_lbus_cyc = ~i_lbus_cyc;
            i_ibus_adr = $urandom;
            i_dbus_adr = $urandom;
            i_dbus_dat = $urandom;
            i_dbus_sel = 4'($urandom);
            i_dbus_we  = 1'($urandom);
            i_lbus_adr = $urandom;
            i_lbus_dat = $urandom;
            i_lbus_sel = 4'($urandom);
            i_lbus_we  = 1'($urandom);
            i_mem_rdt  = $urandom;
            wb_rst     = ($urandom_range(0, 399) == 0);
            tick();
        end
        wb_rst     = 1'b0;
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        i_lbus_cyc = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
